nn_step_engine: RTL and testbench
=================================

Name: nn_step_engine

Overview:
Parametrised, time-multiplexed successor of the pedometer's two-layer step classifier.
- Accepts one accelerometer sample pair (a, b) per transaction through a valid/ready handshake.
- Evaluates a 2-input, HIDDEN-node, 1-output fixed-point network on a single shared multiplier.
- Thresholds the output to a step decision.
- Maintains an edge-counted step total.
- Holds its own weight register file, written by the update-weights instruction. Weights are not supplied as ports.

Parameters:
DATA_W, 10, signed two's-complement width of samples, weights, node results.
FRAC, 4, fractional bits of weights (1.0 = 2^FRAC).
HIDDEN, 2, number of hidden-layer nodes (>=1).
CNT_W, 16, width of step counter.
THRESH, 32, signed output threshold; step = (output > THRESH).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous active-high reset.
in_valid  in  1  transaction request.
in_ready  out  1  engine can accept a transaction.
funct  in  3  instruction: 0 reset, 1 count, 2 update weights, others no-op.
a  in  DATA_W  sample X (funct 1).
b  in  DATA_W  sample Y (funct 1).
wr_addr  in  $clog2(3*HIDDEN)  weight index (funct 2).
wr_data  in  DATA_W  weight value (funct 2).
step_valid  out  1  one-cycle pulse, classification result valid.
step  out  1  classification result, held until next step_valid.
step_count  out  CNT_W  steps counted.
busy  out  1  evaluation in progress (= !in_ready).

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE.
  - All weights = 0; step_count = 0; step = 0; step_valid = 0; prev_step = 0; accumulator = 0.
  - in_ready = 1 in the cycle after reset. Reset mid-evaluation aborts it with no step_valid pulse.
- Handshake:
  - in_ready = (state == IDLE).
  - A transfer occurs on an edge where in_valid && in_ready. Inputs are sampled only then.
- funct 2: weight[wr_addr] <= wr_data at the transfer edge. State stays IDLE.
  - Addresses >= 3*HIDDEN are ignored.
  - Weight map: theta for hidden node k at addresses 2k (multiplies a) and 2k+1 (multiplies b); alpha_k at 2*HIDDEN+k.
- funct 0: step_count <= 0 and prev_step <= 0. Weights and step are retained. State stays IDLE.
- funct 3..7: consumed, no effect.
- funct 1: a and b are latched and the state goes IDLE -> L1.
  - L1: 2*HIDDEN cycles, one MAC per cycle, in order node 0 theta(a), node 0 theta(b), node 1 ...
    - After each node's second MAC: h_k <= sat(acc >>> FRAC) and acc is cleared.
  - L2: HIDDEN cycles, acc += h_k*alpha_k.
  - ACT: 1 cycle.
    - y = sat(acc >>> FRAC); step <= (y > THRESH); step_valid <= 1.
    - Counter: if step && !prev_step && step_count != max, step_count += 1. Saturate at 2^CNT_W-1.
    - prev_step <= step. State returns to IDLE.
- Latency: step_valid is high in cycle 3*HIDDEN+1 after the accept edge (7 for HIDDEN=2). A new transfer may occur on the same edge that step_valid rises.
- Arithmetic:
  - Product width 2*DATA_W.
  - Accumulator width 2*DATA_W+$clog2(HIDDEN)+1. No overflow is possible.
  - The shift is arithmetic.
  - sat clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Only one multiplier is permitted.

Decomposition:
- Package nn_step_pkg:
  - funct encodings FUNCT_RESET=3'd0, FUNCT_COUNT=3'd1, FUNCT_UPDATE=3'd2.
  - State enum IDLE/L1/L2/ACT.
  - Weight-address helper functions.
- Sub-module nn_mac_sat:
  - Multiply-accumulate with clear and saturating FRAC rescale.
  - Shared by both layers.
- FSM, weight file and counter live in nn_step_engine.

Test Plan:
- Load all thetas and alphas = 16; funct 1 with a=10, b=20 -> h=30,30, y=60, step_valid at cycle 7, step=1, step_count=1.
- Repeat the same sample -> step=1, step_count stays 1. Then a=0, b=0 -> step=0. Then a=10, b=20 -> step_count=2.
- Thetas = -16 (10'h3F0), alphas = 16, a=10, b=20 -> y=-60, step=0, count unchanged. Then a=511, b=511 with thetas = 16 -> h saturates to 511, y=511, step=1.
- funct 2 to wr_addr=6 (HIDDEN=2) -> no weight changes, verified by a rerun of scenario 1. funct 5 -> no state change, in_ready stays 1.
- funct 0 after step_count=2 -> count=0, weights intact, next step=1 sample counts to 1. Force count to 2^16-1 -> the next edge stays saturated.
- rst asserted 3 cycles into an evaluation -> no step_valid, in_ready=1 next cycle, count=0. A rerun of scenario 1 gives y=0, step=0 (weights cleared).

Source files
------------

// File: rtl/nn_step_pkg.sv
// Shared encodings and weight-address helpers for the step classifier engine.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package nn_step_pkg;

  localparam logic [2:0] FUNCT_RESET  = 3'd0;
  localparam logic [2:0] FUNCT_COUNT  = 3'd1;
  localparam logic [2:0] FUNCT_UPDATE = 3'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    L1   = 2'd1,
    L2   = 2'd2,
    ACT  = 2'd3
  } state_t;

  // Total number of weights held for a given hidden-layer size.
  function automatic int num_weights(input int hidden);
    return 3 * hidden;
  endfunction

  // Theta for hidden node k; sel 0 multiplies sample a, sel 1 multiplies b.
  function automatic int theta_addr(input int k, input int sel);
    return 2 * k + sel;
  endfunction

  // Output-layer weight alpha_k sits after all thetas.
  function automatic int alpha_addr(input int hidden, input int k);
    return 2 * hidden + k;
  endfunction

endpackage

// File: rtl/nn_mac_sat.sv
// Single-multiplier accumulate with clear, plus saturating >>>FRAC rescale of the running sum.
// Latency: sat_out is combinational from acc_q and this cycle's product; acc_q updates next edge.
// Backpressure: none; the caller sequences mac_en/clr every cycle.
module nn_mac_sat
  import nn_step_pkg::*;
#(
  parameter int DATA_W = 10,
  parameter int FRAC   = 4,
  parameter int ACC_W  = 2 * DATA_W + 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mac_en,
  input  logic                     clr,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [DATA_W-1:0] w,
  output logic signed [DATA_W-1:0] sat_out
);

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(1 << (DATA_W - 1)));

  logic signed [ACC_W-1:0]    acc_q;
  logic signed [ACC_W-1:0]    acc_d;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    sum;
  logic signed [ACC_W-1:0]    shifted;

  // The one shared multiplier; the sum is what the accumulator would hold after this MAC.
  always_comb begin
    prod    = x * w;
    sum     = mac_en ? (acc_q + {{(ACC_W - 2*DATA_W){prod[2*DATA_W-1]}}, prod}) : acc_q;
    shifted = sum >>> FRAC;
    if (shifted > SAT_MAX) begin
      sat_out = SAT_MAX[DATA_W-1:0];
    end else if (shifted < SAT_MIN) begin
      sat_out = SAT_MIN[DATA_W-1:0];
    end else begin
      sat_out = shifted[DATA_W-1:0];
    end
  end

  // Clear wins over accumulate so a node's last MAC can hand off its result and restart at zero.
  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (mac_en) begin
      acc_d = sum;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/nn_step_engine.sv
// Time-multiplexed 2-in/HIDDEN/1-out step classifier with weight file and edge-counted step total.
// Latency: step_valid pulses 3*HIDDEN+1 edges after a count transfer; other functs take one edge.
// Backpressure: in_ready drops for the whole evaluation; nothing is accepted until IDLE again.
module nn_step_engine
  import nn_step_pkg::*;
#(
  parameter int DATA_W = 10,
  parameter int FRAC   = 4,
  parameter int HIDDEN = 2,
  parameter int CNT_W  = 16,
  parameter int THRESH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [2:0]                    funct,
  input  logic signed [DATA_W-1:0]      a,
  input  logic signed [DATA_W-1:0]      b,
  input  logic [$clog2(3*HIDDEN)-1:0]   wr_addr,
  input  logic signed [DATA_W-1:0]      wr_data,
  output logic                          step_valid,
  output logic                          step,
  output logic [CNT_W-1:0]              step_count,
  output logic                          busy
);

  localparam int NW    = num_weights(HIDDEN);
  localparam int AW    = $clog2(3 * HIDDEN);
  localparam int ACC_W = 2 * DATA_W + $clog2(HIDDEN) + 1;
  // One index walks the weight file: thetas during L1, then alphas during L2.
  localparam logic [AW-1:0] L1_LAST = AW'(theta_addr(HIDDEN - 1, 1));
  localparam logic [AW-1:0] L2_LAST = AW'(alpha_addr(HIDDEN, HIDDEN - 1));

  state_t                   state_q, state_d;
  logic [AW-1:0]            idx_q, idx_d;
  logic signed [DATA_W-1:0] a_q, a_d;
  logic signed [DATA_W-1:0] b_q, b_d;
  logic signed [DATA_W-1:0] w_q [NW];
  logic signed [DATA_W-1:0] w_d [NW];
  logic signed [DATA_W-1:0] h_q [HIDDEN];
  logic signed [DATA_W-1:0] h_d [HIDDEN];
  logic                     step_q, step_d;
  logic                     step_valid_q, step_valid_d;
  logic                     prev_step_q, prev_step_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  logic                     mac_en;
  logic                     mac_clr;
  logic signed [DATA_W-1:0] mac_x;
  logic signed [DATA_W-1:0] mac_w;
  logic signed [DATA_W-1:0] mac_sat;
  logic                     step_new;

  nn_mac_sat #(
    .DATA_W (DATA_W),
    .FRAC   (FRAC),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk     (clk),
    .rst     (rst),
    .mac_en  (mac_en),
    .clr     (mac_clr),
    .x       (mac_x),
    .w       (mac_w),
    .sat_out (mac_sat)
  );

  // Sequencer: handshake decode in IDLE, one MAC per cycle in L1/L2, threshold and count in ACT.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    a_d          = a_q;
    b_d          = b_q;
    w_d          = w_q;
    h_d          = h_q;
    step_d       = step_q;
    step_valid_d = 1'b0;
    prev_step_d  = prev_step_q;
    cnt_d        = cnt_q;
    mac_en       = 1'b0;
    mac_clr      = 1'b0;
    mac_x        = a_q;
    mac_w        = w_q[idx_q];
    step_new     = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          case (funct)
            FUNCT_RESET: begin
              cnt_d       = '0;
              prev_step_d = 1'b0;
            end
            FUNCT_COUNT: begin
              a_d     = a;
              b_d     = b;
              idx_d   = '0;
              state_d = L1;
            end
            FUNCT_UPDATE: begin
              if (int'(wr_addr) < NW) begin
                w_d[wr_addr] = wr_data;
              end
            end
            default: ;
          endcase
        end
      end

      L1: begin
        // Even index multiplies a, odd index multiplies b and closes the node.
        mac_en = 1'b1;
        mac_x  = idx_q[0] ? b_q : a_q;
        if (idx_q[0]) begin
          mac_clr = 1'b1;
          for (int i = 0; i < HIDDEN - 1; i++) begin
            h_d[i] = h_q[i + 1];
          end
          h_d[HIDDEN-1] = mac_sat;
        end
        idx_d = idx_q + AW'(1);
        if (idx_q == L1_LAST) begin
          state_d = L2;
        end
      end

      L2: begin
        // Hidden results drain from the head of the shift chain in node order.
        mac_en = 1'b1;
        mac_x  = h_q[0];
        for (int i = 0; i < HIDDEN - 1; i++) begin
          h_d[i] = h_q[i + 1];
        end
        h_d[HIDDEN-1] = h_q[0];
        idx_d = idx_q + AW'(1);
        if (idx_q == L2_LAST) begin
          idx_d   = '0;
          state_d = ACT;
        end
      end

      ACT: begin
        mac_clr      = 1'b1;
        step_new     = int'(mac_sat) > THRESH;
        step_d       = step_new;
        step_valid_d = 1'b1;
        if (step_new && !prev_step_q && (cnt_q != {CNT_W{1'b1}})) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        prev_step_d = step_new;
        state_d     = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State, datapath and weight registers; reset aborts any evaluation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      step_q       <= 1'b0;
      step_valid_q <= 1'b0;
      prev_step_q  <= 1'b0;
      cnt_q        <= '0;
      for (int i = 0; i < NW; i++) begin
        w_q[i] <= '0;
      end
      for (int i = 0; i < HIDDEN; i++) begin
        h_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      a_q          <= a_d;
      b_q          <= b_d;
      step_q       <= step_d;
      step_valid_q <= step_valid_d;
      prev_step_q  <= prev_step_d;
      cnt_q        <= cnt_d;
      w_q          <= w_d;
      h_q          <= h_d;
    end
  end

  // Output mapping.
  always_comb begin
    in_ready   = (state_q == IDLE);
    busy       = (state_q != IDLE);
    step_valid = step_valid_q;
    step       = step_q;
    step_count = cnt_q;
  end

endmodule

// File: tb/tb_nn_step_engine.sv
// Directed bench for nn_step_engine: default instance plus a 3-bit counter instance on shared stimulus.
// Latency: checks step_valid arrives exactly 7 edges after each count transfer.
// Backpressure: transfers wait (bounded) for in_ready before driving in_valid.
module tb_nn_step_engine;
  import nn_step_pkg::*;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic [2:0]        funct;
  logic signed [9:0] a;
  logic signed [9:0] b;
  logic [2:0]        wr_addr;
  logic signed [9:0] wr_data;

  logic              in_ready, step_valid, step, busy;
  logic [15:0]       step_count;
  logic              s_in_ready, s_step_valid, s_step, s_busy;
  logic [2:0]        s_step_count;

  int n_assert = 0;
  int n_fail   = 0;

  nn_step_engine #(
    .DATA_W(10), .FRAC(4), .HIDDEN(2), .CNT_W(16), .THRESH(32)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .funct(funct),
    .a(a), .b(b), .wr_addr(wr_addr), .wr_data(wr_data), .step_valid(step_valid),
    .step(step), .step_count(step_count), .busy(busy)
  );

  // Same network with a tiny counter so saturation is reachable quickly.
  nn_step_engine #(
    .DATA_W(10), .FRAC(4), .HIDDEN(2), .CNT_W(3), .THRESH(32)
  ) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .funct(funct),
    .a(a), .b(b), .wr_addr(wr_addr), .wr_data(wr_data), .step_valid(s_step_valid),
    .step(s_step), .step_count(s_step_count), .busy(s_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic [2:0] f, input logic [9:0] av, input logic [9:0] bv,
                      input logic [2:0] addr, input logic [9:0] data);
    int guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard == 50) chk("xfer_ready_wait", 32'(in_ready), 32'd1);
    funct    = f;
    a        = av;
    b        = bv;
    wr_addr  = addr;
    wr_data  = data;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    funct    = 3'd7;
  endtask

  task automatic wr(input int addr, input logic [9:0] data);
    xfer(FUNCT_UPDATE, 10'd0, 10'd0, 3'(addr), data);
  endtask

  task automatic eval(input string tag, input logic [9:0] av, input logic [9:0] bv,
                      input logic exp_step, input int exp_cnt, input int exp_sat);
    int lat = 0;
    xfer(FUNCT_COUNT, av, bv, 3'd0, 10'd0);
    while (!step_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd7);
    chk({tag, "_step"}, 32'(step), 32'(exp_step));
    chk({tag, "_count"}, 32'(step_count), 32'(exp_cnt));
    chk({tag, "_satcount"}, 32'(s_step_count), 32'(exp_sat));
    @(posedge clk); #1;
    chk({tag, "_pulse_end"}, 32'(step_valid), 32'd0);
  endtask

  initial begin
    int pulses;
    rst      = 1'b1;
    in_valid = 1'b0;
    funct    = 3'd7;
    a        = '0;
    b        = '0;
    wr_addr  = '0;
    wr_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_step_valid", 32'(step_valid), 32'd0);
    chk("rst_step", 32'(step), 32'd0);
    chk("rst_count", 32'(step_count), 32'd0);

    // All weights 1.0: h = 30,30 and y = 60 for (10,20).
    for (int k = 0; k < 2; k++) begin
      wr(theta_addr(k, 0), 10'd16);
      wr(theta_addr(k, 1), 10'd16);
      wr(alpha_addr(2, k), 10'd16);
    end
    eval("s1", 10'd10, 10'd20, 1'b1, 1, 1);
    eval("s1_repeat", 10'd10, 10'd20, 1'b1, 1, 1);
    eval("zero", 10'd0, 10'd0, 1'b0, 1, 1);
    eval("s1_again", 10'd10, 10'd20, 1'b1, 2, 2);

    // Negative thetas: h = -30,-30, y = -60.
    for (int k = 0; k < 4; k++) wr(k, 10'h3F0);
    eval("neg", 10'd10, 10'd20, 1'b0, 2, 2);

    // Large samples saturate hidden and output to 511.
    for (int k = 0; k < 4; k++) wr(k, 10'd16);
    eval("sat511", 10'd511, 10'd511, 1'b1, 3, 3);

    // Out-of-range writes must not disturb the weights.
    wr(6, 10'h3F0);
    wr(7, 10'h3F0);
    eval("oob_rerun", 10'd10, 10'd20, 1'b1, 3, 3);

    // Undefined funct is consumed without effect.
    xfer(3'd5, 10'd10, 10'd20, 3'd0, 10'h3F0);
    chk("nop_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk("nop_step_valid", 32'(step_valid), 32'd0);
    chk("nop_count", 32'(step_count), 32'd3);

    // Counter clear keeps weights and the last step value.
    xfer(FUNCT_RESET, 10'd0, 10'd0, 3'd0, 10'd0);
    chk("clr_count", 32'(step_count), 32'd0);
    chk("clr_step_kept", 32'(step), 32'd1);
    eval("after_clr", 10'd10, 10'd20, 1'b1, 1, 1);

    // Threshold is strict: y = 32 is no step, y = 34 is a step.
    eval("thr_eq", 10'd16, 10'd0, 1'b0, 1, 1);
    eval("thr_above", 10'd16, 10'd1, 1'b1, 2, 2);

    // Alternate edges; the 3-bit counter must pin at 7.
    for (int i = 0; i < 6; i++) begin
      eval("alt_low", 10'd0, 10'd0, 1'b0, 2 + i, (2 + i > 7) ? 7 : 2 + i);
      eval("alt_high", 10'd10, 10'd20, 1'b1, 3 + i, (3 + i > 7) ? 7 : 3 + i);
    end

    // Reset three cycles into an evaluation aborts it and clears everything.
    xfer(FUNCT_COUNT, 10'd10, 10'd20, 3'd0, 10'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_count", 32'(step_count), 32'd0);
    chk("abort_satcount", 32'(s_step_count), 32'd0);
    chk("abort_step", 32'(step), 32'd0);
    pulses = 0;
    repeat (12) begin
      if (step_valid) pulses++;
      @(posedge clk); #1;
    end
    chk("abort_no_pulse", 32'(pulses), 32'd0);
    eval("cleared_weights", 10'd10, 10'd20, 1'b0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
